// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts
// one byte plus odd parity out on device clock falls and checks the device ack.
module ps2_tx #(
    parameter int unsigned INHIBIT_CYC  = 5000,
    parameter int unsigned START_TO_CYC = 750000,
    parameter int unsigned FRAME_TO_CYC = 100000,
    parameter int unsigned FILT_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    output logic       rx_inhibit_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT1, S_XFER, S_ACK, S_WAITREL, S_DONE, S_ERR
    } state_t;

    localparam logic [19:0] L_INH_END   = 20'(INHIBIT_CYC - 1);
    localparam logic [19:0] L_START_END = 20'(START_TO_CYC - 1);
    localparam logic [19:0] L_FRAME_END = 20'(FRAME_TO_CYC - 1);

    logic [1:0]          r_clk_sync, r_dat_sync;
    logic [FILT_LEN-2:0] r_clk_hist, r_dat_hist;
    logic                r_clk_filt, r_dat_filt;
    logic [FILT_LEN-1:0] w_clk_win, w_dat_win;
    logic                w_fall;

    state_t      r_state, w_state_n;
    logic [19:0] r_cnt, w_cnt_n, r_fcnt, w_fcnt_n;
    logic [3:0]  r_bitcnt, w_bitcnt_n;
    logic [7:0]  r_shreg, w_shreg_n;
    logic        r_par, w_par_n;
    logic        r_clk_oe, w_clk_oe_n, r_data_oe, w_data_oe_n;
    logic        w_in_frame, w_in_frame_n;

    // Window = last FILT_LEN synchronized samples; the fall is seen the same cycle
    // the filtered clock is updated to 0.
    assign w_clk_win = {r_clk_hist, r_clk_sync[1]};
    assign w_dat_win = {r_dat_hist, r_dat_sync[1]};
    assign w_fall    = r_clk_filt & ~(|w_clk_win);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_hist <= '1;
            r_dat_hist <= '1;
            r_clk_filt <= 1'b1;
            r_dat_filt <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
            r_dat_sync <= {r_dat_sync[0], ps2_data_i};
            r_clk_hist <= w_clk_win[FILT_LEN-2:0];
            r_dat_hist <= w_dat_win[FILT_LEN-2:0];
            if (&w_clk_win)
                r_clk_filt <= 1'b1;
            else if (~(|w_clk_win))
                r_clk_filt <= 1'b0;
            if (&w_dat_win)
                r_dat_filt <= 1'b1;
            else if (~(|w_dat_win))
                r_dat_filt <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_fcnt    <= '0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_fcnt    <= w_fcnt_n;
            r_bitcnt  <= w_bitcnt_n;
            r_shreg   <= w_shreg_n;
            r_par     <= w_par_n;
            r_clk_oe  <= w_clk_oe_n;
            r_data_oe <= w_data_oe_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_bitcnt_n  = r_bitcnt;
        w_shreg_n   = r_shreg;
        w_par_n     = r_par;
        w_clk_oe_n  = r_clk_oe;
        w_data_oe_n = r_data_oe;
        case (r_state)
            S_IDLE: begin
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                if (tx_start_i) begin
                    w_shreg_n  = tx_data_i;
                    w_par_n    = ~^tx_data_i;
                    w_bitcnt_n = '0;
                    w_state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_clk_oe_n = 1'b1;
                if (r_cnt == L_INH_END) begin
                    w_data_oe_n = 1'b1;
                    w_state_n   = S_REQ;
                end
            end
            S_REQ: begin
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b1;
                w_state_n   = S_WAIT1;
            end
            S_WAIT1: begin
                if (w_fall) begin
                    w_bitcnt_n  = 4'd1;
                    w_data_oe_n = ~r_shreg[0];
                    w_shreg_n   = {1'b0, r_shreg[7:1]};
                    w_state_n   = S_XFER;
                end else if (r_cnt == L_START_END) begin
                    w_data_oe_n = 1'b0;
                    w_state_n   = S_ERR;
                end
            end
            S_XFER: begin
                if (w_fall) begin
                    w_bitcnt_n = r_bitcnt + 4'd1;
                    if (r_bitcnt < 4'd8) begin
                        w_data_oe_n = ~r_shreg[0];
                        w_shreg_n   = {1'b0, r_shreg[7:1]};
                    end else if (r_bitcnt == 4'd8) begin
                        w_data_oe_n = ~r_par;
                    end else begin
                        w_data_oe_n = 1'b0;
                        w_state_n   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fall)
                    w_state_n = r_dat_filt ? S_ERR : S_WAITREL;
            end
            S_WAITREL: begin
                if (r_clk_filt && r_dat_filt)
                    w_state_n = S_DONE;
            end
            default: begin
                w_clk_oe_n  = 1'b0;
                w_data_oe_n = 1'b0;
                w_state_n   = S_IDLE;
            end
        endcase

        // Frame timeout overrides whatever the per-state logic decided.
        w_in_frame = (r_state == S_XFER) || (r_state == S_ACK) || (r_state == S_WAITREL);
        if (w_in_frame && (r_fcnt == L_FRAME_END)) begin
            w_clk_oe_n  = 1'b0;
            w_data_oe_n = 1'b0;
            w_state_n   = S_ERR;
        end
        w_in_frame_n = (w_state_n == S_XFER) || (w_state_n == S_ACK) || (w_state_n == S_WAITREL);
        w_cnt_n  = (w_state_n != r_state) ? '0 : r_cnt + 20'd1;
        w_fcnt_n = (w_in_frame && w_in_frame_n) ? r_fcnt + 20'd1 : '0;
    end

    assign tx_busy_o     = (r_state != S_IDLE);
    assign rx_inhibit_o  = tx_busy_o;
    assign tx_done_o     = (r_state == S_DONE);
    assign tx_err_o      = (r_state == S_ERR);
    assign ps2_clk_oe_o  = r_clk_oe;
    assign ps2_data_oe_o = r_data_oe;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: behavioural PS/2 device on open-drain lines, expected frames
// built from the byte with plain arithmetic, directed and random sends.
module tb_ps2_tx;

    localparam int INH   = 60;
    localparam int START = 2000;
    localparam int FRAME = 1200;
    localparam int H     = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err, rx_inh;
    logic       clk_oe, data_oe;
    logic       dev_clk, dev_data;
    logic       pin_clk, pin_data;

    int checks = 0, failures = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_inh_mis = 0;
    int oe_run = 0, last_run = 0;

    logic [10:0] got;
    bit          ok, found;
    logic [7:0]  b;
    int          c, d0, e0;

    assign pin_clk  = dev_clk & ~clk_oe;
    assign pin_data = dev_data & ~data_oe;

    ps2_tx #(
        .INHIBIT_CYC (INH),
        .START_TO_CYC(START),
        .FRAME_TO_CYC(FRAME),
        .FILT_LEN    (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_data_i    (tx_data),
        .tx_start_i   (tx_start),
        .tx_busy_o    (tx_busy),
        .tx_done_o    (tx_done),
        .tx_err_o     (tx_err),
        .rx_inhibit_o (rx_inh),
        .ps2_clk_i    (pin_clk),
        .ps2_data_i   (pin_data),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        if (tx_done && tx_err) n_both++;
        if (rx_inh !== tx_busy) n_inh_mis++;
        if (clk_oe) oe_run++;
        else begin
            if (oe_run != 0) last_run = oe_run;
            oe_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line order as seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] v);
        return {1'b1, ($countones(v) % 2 == 0) ? 1'b1 : 1'b0, v, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] v);
        @(negedge clk);
        tx_data  = v;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic dev_frame(input bit ack, input int glitch_k, input int inj_k, input int nclk,
                             output logic [10:0] bits, output bit req_ok);
        bit seen;
        bits   = '1;
        req_ok = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = clk_oe;
        end
        for (int i = 0; i < INH + 20 && seen && !req_ok; i++) begin
            @(negedge clk);
            req_ok = !clk_oe && data_oe;
        end
        if (!req_ok) return;
        for (int k = 1; k <= nclk; k++) begin
            for (int cy = 0; cy < H; cy++) begin
                @(negedge clk);
                if (k == glitch_k && cy == 3) dev_clk = 1'b0;
                if (k == glitch_k && cy == 5) dev_clk = 1'b1;
                if (k == inj_k && cy == 1) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                end
                if (k == inj_k && cy == 2) tx_start = 1'b0;
                if (cy == H / 2) begin
                    bits[k-1] = pin_data;
                    if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
                end
            end
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {clk_oe, data_oe, tx_busy, tx_done, tx_err, rx_inh}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED with ack
        d0 = n_done; e0 = n_err;
        start_tx(8'hED);
        dev_frame(1'b1, 0, 0, 11, got, ok);
        check("t1_req", ok, 1);
        check("t1_bits", got, frame_bits(8'hED));
        repeat (20) @(negedge clk);
        check("t1_inhibit_len", last_run, INH);
        check("t1_done", n_done - d0, 1);
        check("t1_no_err", n_err - e0, 0);
        check("t1_released", {clk_oe, data_oe, tx_busy}, 0);

        // random bytes with ack
        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom);
            d0 = n_done;
            start_tx(b);
            dev_frame(1'b1, 0, 0, 11, got, ok);
            check("rand_bits", got, frame_bits(b));
            repeat (20) @(negedge clk);
            check("rand_done", n_done - d0, 1);
        end

        // back-to-back 0x01 then 0xFF, second start raised in the done cycle
        d0 = n_done;
        start_tx(8'h01);
        dev_frame(1'b1, 0, 0, 11, got, ok);
        check("t2_bits01", got, frame_bits(8'h01));
        check("t2_par01", got[9], 0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            found = tx_done;
        end
        check("t2_done_seen", found, 1);
        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge clk);
        check("t2_idle_gap", tx_busy, 0);
        @(negedge clk);
        check("t2_accept", tx_busy, 1);
        tx_start = 1'b0;
        dev_frame(1'b1, 0, 0, 11, got, ok);
        check("t2_bitsFF", got, frame_bits(8'hFF));
        check("t2_parFF", got[9], 1);
        repeat (20) @(negedge clk);
        check("t2_done_cnt", n_done - d0, 2);

        // device never clocks
        @(negedge clk);
        tx_data = 8'h3C; tx_start = 1'b1;
        c = 0; found = 1'b0;
        while (c < START + INH + 100 && !found) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) tx_start = 1'b0;
            found = tx_err;
        end
        check("t3_err_seen", found, 1);
        check("t3_err_latency", c - 1, START + INH + 1);
        @(posedge clk);
        #1;
        check("t3_lines_released", {clk_oe, data_oe}, 0);

        // nack
        d0 = n_done; e0 = n_err;
        start_tx(8'hA5);
        dev_frame(1'b0, 0, 0, 11, got, ok);
        repeat (20) @(negedge clk);
        check("t4_bits", got, frame_bits(8'hA5));
        check("t4_err", n_err - e0, 1);
        check("t4_no_done", n_done - d0, 0);

        // short low glitch on the clock pin during the data bits
        b = 8'($urandom);
        d0 = n_done;
        start_tx(b);
        dev_frame(1'b1, 4, 0, 11, got, ok);
        check("t6_bits", got, frame_bits(b));
        repeat (20) @(negedge clk);
        check("t6_done", n_done - d0, 1);

        // start pulse with a different byte in the middle of a frame
        d0 = n_done;
        start_tx(8'hAA);
        dev_frame(1'b1, 0, 5, 11, got, ok);
        check("t5_bits", got, frame_bits(8'hAA));
        repeat (20) @(negedge clk);
        check("t5_done", n_done - d0, 1);
        check("t5_not_queued", tx_busy, 0);

        // device stops clocking mid-frame: frame timeout
        d0 = n_done;
        start_tx(8'h0F);
        dev_frame(1'b1, 0, 0, 5, got, ok);
        found = 1'b0;
        for (int i = 0; i < FRAME + 100 && !found; i++) begin
            @(negedge clk);
            found = tx_err;
        end
        check("frame_to_err", found, 1);
        @(negedge clk);
        check("frame_to_released", {clk_oe, data_oe, tx_busy}, 0);
        check("frame_to_no_done", n_done - d0, 0);

        // asynchronous reset in the middle of a frame
        d0 = n_done; e0 = n_err;
        start_tx(8'hAA);
        dev_frame(1'b1, 0, 0, 4, got, ok);
        check("rst_mid_busy_before", tx_busy, 1);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_outputs", {clk_oe, data_oe, tx_busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_mid_quiet", {n_done - d0, n_err - e0}, 0);

        check("never_done_and_err", n_both, 0);
        check("inhibit_follows_busy", n_inh_mis, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
